// File: rtl/serializer_scheduler_if.sv
// Handshake/bus bundle between word sources and the serializer scheduler.
//   pause      : hold off new grants (in-flight word completes)
//   req_valid  : per-requester word available
//   req_data   : word i at bits [i*WORD_W +: WORD_W]
//   req_ready  : per-requester accept strobe (combinational)
//   ser_enable : one-cycle serializer load pulse
//   ser_word   : word presented to the serializer
//   grant_id   : requester owning the current slot
//   busy       : scheduler is in a slot (not IDLE)
// Modports: master = requester/transmit-path side, slave = scheduler.
interface serializer_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 24
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      pause;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ser_enable;
  logic [WORD_W-1:0]         ser_word;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport master (
    output pause, req_valid, req_data,
    input  req_ready, ser_enable, ser_word, grant_id, busy
  );

  modport slave (
    input  pause, req_valid, req_data,
    output req_ready, ser_enable, ser_word, grant_id, busy
  );
endinterface

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one WORD_W -> nibble serializer among
// NUM_REQ word sources.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   bus      : serializer_scheduler_if.slave (requests in, serializer out)
//   word_cnt : saturating accept counter, present only when
//              SCHED_WORD_CNT_EN is defined
// Slot: LOAD (1 cycle, ser_enable=1) -> SHIFT (SER_CYCLES) -> GAP
// (GAP_CYCLES, skipped when 0) -> IDLE. Accepts happen only in IDLE, so a
// continuously valid source is served once every 2+SER_CYCLES+GAP_CYCLES
// cycles (slot plus the IDLE cycle carrying the handshake).
module serializer_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int WORD_W     = 24,
  parameter int SER_CYCLES = 6,
  parameter int GAP_CYCLES = 1
) (
  input logic                   clk,
  input logic                   reset,
  serializer_scheduler_if.slave bus
`ifdef SCHED_WORD_CNT_EN
  ,
  output logic [15:0]           word_cnt
`endif
);
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_CNT = (SER_CYCLES > GAP_CYCLES) ? SER_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    ptr, sel, cand;
  logic               any_valid, accept;
  logic [NUM_REQ-1:0] ready;
  logic               ser_enable_q;
  logic [WORD_W-1:0]  ser_word_q;
  logic [ID_W-1:0]    grant_q;
  int                 idx;

  // Rotating priority search starting at ptr. Walking the offsets from the
  // far end lets the nearest valid requester win by being written last.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (bus.req_valid[cand]) begin
        sel       = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Gating with reset keeps req_ready low for the whole time reset is held,
  // not just after the next clock edge.
  assign accept = reset && (state == S_IDLE) && !bus.pause && any_valid;

  always_comb begin
    ready = '0;
    if (accept) ready[sel] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt = S_SHIFT;
        cnt_nxt   = CNT_W'(SER_CYCLES - 1);
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = S_GAP;
            cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= '0;
      ser_enable_q <= 1'b0;
      ser_word_q   <= '0;
      grant_q      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      // High exactly while the FSM sits in LOAD.
      ser_enable_q <= (state_nxt == S_LOAD);
      if (accept) begin
        // Word is captured once and held; the serializer samples it live.
        ser_word_q <= bus.req_data[sel*WORD_W +: WORD_W];
        grant_q    <= sel;
        ptr        <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
      end
    end
  end

`ifdef SCHED_WORD_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              word_cnt_q <= '0;
    else if (accept && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_cnt = word_cnt_q;
`endif

  assign bus.req_ready  = ready;
  assign bus.ser_enable = ser_enable_q;
  assign bus.ser_word   = ser_word_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_serializer_scheduler.sv
// Directed bench for serializer_scheduler: default-parameter instance plus a
// GAP_CYCLES=0 instance. Inputs change and outputs are sampled at negedge.
module tb_serializer_scheduler;
  localparam int NR = 2;
  localparam int WW = 24;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  serializer_scheduler_if #(.NUM_REQ(NR), .WORD_W(WW)) bus  ();
  serializer_scheduler_if #(.NUM_REQ(NR), .WORD_W(WW)) bus0 ();

`ifdef SCHED_WORD_CNT_EN
  logic [15:0] word_cnt;
  logic [15:0] word_cnt0;
`endif

  serializer_scheduler #(.NUM_REQ(NR), .WORD_W(WW), .SER_CYCLES(6), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef SCHED_WORD_CNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  serializer_scheduler #(.NUM_REQ(NR), .WORD_W(WW), .SER_CYCLES(6), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
`ifdef SCHED_WORD_CNT_EN
    , .word_cnt(word_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.pause = 1'b0;  bus.req_valid = '0;  bus.req_data = '0;
    bus0.pause = 1'b0; bus0.req_valid = '0; bus0.req_data = '0;
    step(2);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ser_enable !== 1'b0) begin n_fail++; $display("FAIL reset_ser_enable: got %b want 0", bus.ser_enable); end
    n_cmp++; if (bus.ser_word !== 24'h0) begin n_fail++; $display("FAIL reset_ser_word: got %h want 000000", bus.ser_word); end
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %h want 0", bus.grant_id); end
    bus.req_valid = 2'b11; #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL ready_in_reset: got %b want 00", bus.req_ready); end
    // Release, let requester 0 win (ptr -> 1), then abort mid-SHIFT.
    reset = 1'b1; bus.req_valid = 2'b01; bus.req_data[0 +: WW] = 24'h123456; #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL first_ready: got %b want 01", bus.req_ready); end
    step(1); bus.req_valid = '0; step(3);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_shift: got %b want 1", bus.busy); end
    reset = 1'b0; bus.req_valid = 2'b11; bus.req_data[WW +: WW] = 24'h654321; #1;
    n_cmp++;
    if (bus.ser_enable !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_slot_abort: got en=%b busy=%b rdy=%b want 0 0 00", bus.ser_enable, bus.busy, bus.req_ready);
    end
    step(2);
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL ready_held_in_reset: got %b want 00", bus.req_ready); end
    // Pointer must be back at 0: requester 0 wins although 1 is also valid.
    reset = 1'b1; #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ptr_after_reset: got %b want 01", bus.req_ready); end
    step(1); bus.req_valid = '0;
    n_cmp++;
    if (bus.ser_enable !== 1'b1 || bus.grant_id !== 1'b0 || bus.ser_word !== 24'h123456) begin
      n_fail++;
      $display("FAIL grant_after_reset: got en=%b id=%h word=%h want 1 0 123456", bus.ser_enable, bus.grant_id, bus.ser_word);
    end
    step(10);
  endtask

  task automatic test_single_word;
    int en_cnt;
    int busy_cnt;
    int held;
    en_cnt = 0; busy_cnt = 0; held = 1;
    bus.req_data[0 +: WW] = 24'hABCDEF; bus.req_valid = 2'b01; #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
    step(1); bus.req_valid = '0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step(1);
      if (c == 0) begin
        n_cmp++; if (bus.ser_enable !== 1'b1) begin n_fail++; $display("FAIL single_load_pulse: got %b want 1", bus.ser_enable); end
        n_cmp++; if (bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %h want 0", bus.grant_id); end
      end
      if (bus.ser_enable) en_cnt++;
      if (bus.busy) busy_cnt++;
      if (c < 7 && bus.ser_word !== 24'hABCDEF) held = 0;
    end
    n_cmp++; if (en_cnt != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", en_cnt); end
    n_cmp++; if (busy_cnt != 8) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (held != 1) begin n_fail++; $display("FAIL single_word_held: got %0d want 1", held); end
  endtask

  task automatic test_round_robin;
    int pulses;
    int multi;
    int pc[4];
    int pg[4];
    logic [WW-1:0] pw[4];
    logic [WW-1:0] exp_w;
    int exp_g;
    pulses = 0; multi = 0;
    bus.req_data[0 +: WW] = 24'hA0A0A0;
    bus.req_data[WW +: WW] = 24'hB1B1B1;
    bus.req_valid = 2'b11; #1;
    // Pointer sits at 1 after the previous grant to requester 0.
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL rr_first_ready: got %b want 10", bus.req_ready); end
    for (int c = 0; c < 36; c++) begin
      step(1);
      if ($countones(bus.req_ready) > 1) multi++;
      if (bus.ser_enable) begin
        if (pulses < 4) begin
          pc[pulses] = c; pg[pulses] = int'(bus.grant_id); pw[pulses] = bus.ser_word;
        end
        pulses++;
      end
    end
    bus.req_valid = '0;
    n_cmp++; if (pulses != 4) begin n_fail++; $display("FAIL rr_pulse_count: got %0d want 4", pulses); end
    n_cmp++; if (multi != 0) begin n_fail++; $display("FAIL rr_multi_ready: got %0d want 0", multi); end
    if (pulses >= 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_g = (i % 2 == 0) ? 1 : 0;
        exp_w = (exp_g == 1) ? 24'hB1B1B1 : 24'hA0A0A0;
        n_cmp++; if (pg[i] != exp_g) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, pg[i], exp_g); end
        n_cmp++; if (pw[i] !== exp_w) begin n_fail++; $display("FAIL rr_word_%0d: got %h want %h", i, pw[i], exp_w); end
        n_cmp++; if (pc[i] != 9 * i) begin n_fail++; $display("FAIL rr_pulse_cycle_%0d: got %0d want %0d", i, pc[i], 9 * i); end
      end
    end
    step(2);
  endtask

  task automatic test_pause;
    int bad_rdy;
    int en;
    int held;
    bad_rdy = 0; en = 0; held = 1;
    bus.req_data[0 +: WW] = 24'hC0FFEE;
    bus.req_data[WW +: WW] = 24'h0BEEF1;
    bus.req_valid = 2'b01; #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL pause_first_ready: got %b want 01", bus.req_ready); end
    step(1);
    n_cmp++; if (bus.ser_enable !== 1'b1) begin n_fail++; $display("FAIL pause_load: got %b want 1", bus.ser_enable); end
    bus.pause = 1'b1; bus.req_valid = 2'b11;
    for (int c = 1; c <= 14; c++) begin
      step(1);
      if (bus.req_ready !== 2'b00) bad_rdy++;
      if (bus.ser_enable) en++;
      if (c <= 6 && bus.ser_word !== 24'hC0FFEE) held = 0;
    end
    n_cmp++; if (bad_rdy != 0) begin n_fail++; $display("FAIL pause_ready_blocked: got %0d want 0", bad_rdy); end
    n_cmp++; if (en != 0) begin n_fail++; $display("FAIL pause_no_new_load: got %0d want 0", en); end
    n_cmp++; if (held != 1) begin n_fail++; $display("FAIL pause_word_completes: got %0d want 1", held); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL pause_parked_idle: got %b want 0", bus.busy); end
    bus.pause = 1'b0; #1;
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL pause_release_ready: got %b want 10", bus.req_ready); end
    step(1);
    n_cmp++;
    if (bus.ser_enable !== 1'b1 || bus.grant_id !== 1'b1 || bus.ser_word !== 24'h0BEEF1) begin
      n_fail++;
      $display("FAIL pause_resume_grant: got en=%b id=%h word=%h want 1 1 0beef1", bus.ser_enable, bus.grant_id, bus.ser_word);
    end
    bus.req_valid = '0;
    step(10);
  endtask

  task automatic test_gap0;
    int pulses;
    int pc[3];
    int bad_id;
    logic b6;
    logic b7;
    pulses = 0; bad_id = 0; b6 = 1'b0; b7 = 1'b1;
    bus0.req_data[0 +: WW] = 24'h5A5A5A; bus0.req_valid = 2'b01; #1;
    n_cmp++; if (bus0.req_ready !== 2'b01) begin n_fail++; $display("FAIL gap0_first_ready: got %b want 01", bus0.req_ready); end
    for (int c = 0; c < 24; c++) begin
      step(1);
      if (c == 6) b6 = bus0.busy;
      if (c == 7) b7 = bus0.busy;
      if (bus0.ser_enable) begin
        if (pulses < 3) pc[pulses] = c;
        if (bus0.grant_id !== 1'b0 || bus0.ser_word !== 24'h5A5A5A) bad_id++;
        pulses++;
      end
    end
    bus0.req_valid = '0;
    n_cmp++; if (pulses != 3) begin n_fail++; $display("FAIL gap0_pulse_count: got %0d want 3", pulses); end
    n_cmp++; if (bad_id != 0) begin n_fail++; $display("FAIL gap0_grant_word: got %0d bad want 0", bad_id); end
    n_cmp++; if (b6 !== 1'b1) begin n_fail++; $display("FAIL gap0_busy_last_shift: got %b want 1", b6); end
    n_cmp++; if (b7 !== 1'b0) begin n_fail++; $display("FAIL gap0_no_gap: got %b want 0", b7); end
    if (pulses >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (pc[i] != 8 * i) begin n_fail++; $display("FAIL gap0_pulse_cycle_%0d: got %0d want %0d", i, pc[i], 8 * i); end
      end
    end
    step(2);
  endtask

`ifdef SCHED_WORD_CNT_EN
  task automatic test_word_cnt;
    reset = 1'b0; step(1);
    n_cmp++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL cnt_reset: got %h want 0000", word_cnt); end
    reset = 1'b1;
    bus.req_data[WW +: WW] = 24'h777777; bus.req_valid = 2'b10;
    for (int c = 0; c < 45; c++) step(1);
    bus.req_valid = '0;
    n_cmp++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt_five: got %0d want 5", word_cnt); end
    step(2);
    force dut.word_cnt_q = 16'hFFFF;
    step(1);
    release dut.word_cnt_q;
    bus.req_valid = 2'b01; step(1); bus.req_valid = '0; step(9);
    n_cmp++; if (word_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffff", word_cnt); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset;
    test_single_word;
    test_round_robin;
    test_pause;
    test_gap0;
`ifdef SCHED_WORD_CNT_EN
    test_word_cnt;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
